mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch and next-PC unit for the next-generation MIPS core.
- Replaces the single-cycle PC register, PC+4 adder and branch/jump muxes with one sequential block.
- Adds a request/acknowledge handshake so instruction memory may insert wait states, a pipeline stall input, jr target alignment checking, and a retired-instruction counter.
- Sits between program memory and the decode/register-file stage.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width; legal range 16..32.
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset; truncated to ADDR_WIDTH.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high until acknowledged.
- imem_addr  out  ADDR_WIDTH  word address for the fetch; equals pc_out.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- stall  in  1  downstream is not ready; hold the current instruction.
- branch_eq  in  1  decoded beq.
- branch_ne  in  1  decoded bne.
- zero  in  1  ALU zero flag for the current instruction.
- jump  in  1  decoded j or jal.
- jump_reg  in  1  decoded jr.
- rs_value  in  ADDR_WIDTH  register rs contents, used as the jr target.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr is valid for decode/execute.
- pc_out  out  ADDR_WIDTH  PC of the current instruction.
- pc_plus4  out  ADDR_WIDTH  pc_out+4; also the jal link value.
- misaligned  out  1  one-cycle pulse: a jr target with nonzero bits [1:0] was committed.
- retired_count  out  CNT_WIDTH  number of committed instructions.

Behaviour:
- Reset (one clk, synchronous, active-high):
  - pc=RESET_VECTOR, state=FETCH, instr=0, instr_valid=0, misaligned=0, retired_count=0.
  - imem_ack is ignored while reset is high.
- State machine, two states:
  - FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ack=1, instr<=imem_rdata and state->VALID. With imem_ack=0, stay in FETCH and keep imem_req high.
  - VALID: imem_req=0, instr_valid=1.
    - stall=1: hold everything; pc, instr and retired_count do not change.
    - stall=0 (commit edge): pc<=next_pc, retired_count<=retired_count+1 (wraps modulo 2^CNT_WIDTH), state->FETCH, instr_valid falls.
- Timing: with zero-wait memory (imem_ack in the first FETCH cycle) throughput is one instruction per 2 cycles; each additional cycle of ack latency adds one cycle.
- Outputs registered: imem_req, instr_valid, instr, pc_out, retired_count, misaligned. pc_plus4 is combinational from pc.
- next_pc priority, highest first, evaluated on the commit edge:
  - jump_reg: target = {rs_value[AW-1:2], 2'b00}. If rs_value[1:0] != 0, misaligned=1 for the next cycle only.
  - jump: target = {pc_plus4[AW-1:28], instr[25:0], 2'b00}. When AW ≤ 28, the target is the low AW bits of {instr[25:0], 2'b00}.
  - (branch_eq & zero) | (branch_ne & ~zero): target = pc_plus4 + (sign_extend(instr[15:0]) << 2), modulo 2^AW.
  - Otherwise: target = pc_plus4.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH. pc=max-3 plus 4 wraps to 0 with no flag.
- Decode inputs are sampled only on the commit edge; their values at any other time are don't-care.
- Simultaneous reset with ack or commit: reset wins; no count increment, no misaligned pulse.
- Reset asserted mid-fetch: a late ack after reset is a new fetch ack for RESET_VECTOR.
- A stall asserted while in FETCH has no effect; it only holds the unit in VALID.

Test Plan:
- Reset, then zero-wait memory returning nops (0x00000000):
  - pc_out sequence 0x00400000, 0x00400004, 0x00400008.
  - instr_valid high every other cycle.
  - retired_count=3 after 6 cycles.
- beq (imm=0x0003) at 0x00400000, branch_eq=1, zero=1 -> next pc_out=0x00400010.
- Same instruction with branch_ne=1, zero=1 -> next pc_out=0x00400004.
- Negative offset: imm=0xFFFF with bne taken at 0x00400010 -> next pc_out=0x00400010.
- j: instr=0x08100008, jump=1 at 0x00400004 -> next pc_out=0x00400020.
- jr: rs_value=0x00400031, jump_reg=1 and jump=1 -> next pc_out=0x00400030, misaligned high for exactly one cycle.
- Wait states and stall:
  - ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr stable, instr_valid rises the cycle after ack.
  - Then stall=1 for 4 cycles -> pc_out, instr and retired_count unchanged; commit occurs on the first edge with stall=0.
- Mid-operation reset: reset pulsed while in VALID with pc=0x00400020 and retired_count=5:
  - Next cycle: pc_out=0x00400000, retired_count=0, instr_valid=0, imem_req=1.
  - An ack sampled during the reset cycle is ignored.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction fetch and next-PC unit: fetches over a req/ack handshake,
// holds the instruction for decode, and commits next_pc when not stalled.
module mips_fetch_unit #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic [ADDR_WIDTH-1:0] rs_value,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  misaligned,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  localparam int AW = ADDR_WIDTH;

  typedef enum logic {FETCH, VALID} state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] jr_target;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] branch_target;
  logic [31:0]   branch_offset;
  logic [27:0]   jump_field;
  logic          take_branch;
  logic          commit;

  assign pc_plus4    = pc + AW'(4);
  assign pc_out      = pc;
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign commit      = (state == VALID) && !stall;

  assign jr_target     = {rs_value[AW-1:2], 2'b00};
  assign jump_field    = {instr[25:0], 2'b00};
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset[AW-1:0];
  assign take_branch   = (branch_eq && zero) || (branch_ne && !zero);

  // Narrow address spaces have no region bits to inherit from pc_plus4.
  if (AW > 28) begin : g_wide_jump
    assign jump_target = {pc_plus4[AW-1:28], jump_field};
  end else begin : g_narrow_jump
    assign jump_target = jump_field[AW-1:0];
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    next_pc = pc_plus4;
    if (jump_reg)         next_pc = jr_target;
    else if (jump)        next_pc = jump_target;
    else if (take_branch) next_pc = branch_target;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (imem_ack) state_next = VALID;
      VALID: if (!stall)   state_next = FETCH;
      default:             state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR[AW-1:0];
      instr         <= '0;
      misaligned    <= 1'b0;
      retired_count <= '0;
    end else begin
      misaligned <= commit && jump_reg && (rs_value[1:0] != 2'b00);
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (commit) begin
        pc            <= next_pc;
        retired_count <= retired_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: a driver issues fetches and commits
// against a program-level reference model; a monitor checks what the DUT presents.
module tb_mips_fetch_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_eq, branch_ne, zero, jump, jump_reg;
  logic [31:0] rs_value;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out, pc_plus4;
  logic        misaligned;
  logic [31:0] retired_count;

  mips_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero), .jump(jump),
    .jump_reg(jump_reg), .rs_value(rs_value), .instr(instr),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .misaligned(misaligned), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] cnt;
  } txn_t;

  txn_t exp_q[$];
  bit   mis_q[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] model_pc;
  logic [31:0] model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural next-PC rule computed directly from the instruction fields.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                               input bit beq, input bit bne, input bit zr,
                                               input bit j, input bit jr, input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (jr) return rs & ~32'h3;
    if (j)  return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
    if ((beq && zr) || (bne && !zr)) begin
      off = int'($signed(ins[15:0])) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  task automatic scramble();
    branch_eq = 1'($urandom);
    branch_ne = 1'($urandom);
    zero      = 1'($urandom);
    jump      = 1'($urandom);
    jump_reg  = 1'($urandom);
    rs_value  = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_pc  = RV;
    model_cnt = 32'd0;
  endtask

  // Fetch with lat wait cycles, hold for nstall cycles, then commit with the given decode.
  task automatic issue(input int lat, input logic [31:0] ins, input int nstall,
                       input bit beq, input bit bne, input bit zr, input bit j,
                       input bit jr, input logic [31:0] rs);
    txn_t t;
    t.pc = model_pc; t.ins = ins; t.cnt = model_cnt;
    exp_q.push_back(t);
    for (int i = 0; i < lat; i++) begin
      check("req_wait", 32'(imem_req), 32'd1);
      check("addr_wait", imem_addr, model_pc);
      scramble();
      stall      = 1'($urandom);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    check("req_ack", 32'(imem_req), 32'd1);
    check("addr_ack", imem_addr, model_pc);
    scramble();
    stall      = 1'($urandom);
    imem_ack   = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < nstall; i++) begin
      scramble();
      stall = 1'b1;
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc_out, model_pc);
      check("stall_instr", instr, ins);
      check("stall_count", retired_count, model_cnt);
    end
    stall     = 1'b0;
    branch_eq = beq; branch_ne = bne; zero = zr; jump = j; jump_reg = jr; rs_value = rs;
    mis_q.push_back(jr && (rs[1:0] != 2'b00));
    @(negedge clk);
    model_pc  = ref_next_pc(model_pc, ins, beq, bne, zr, j, jr, rs);
    model_cnt = model_cnt + 32'd1;
    scramble();
  endtask

  // Monitor: compares on the first cycle instr_valid is presented and on the cycle after each commit.
  bit prev_v = 1'b0;
  always @(posedge clk) begin
    logic rst_s;
    txn_t t;
    bit   m;
    rst_s = reset;
    #1;
    if (!rst_s) begin
      if (instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          t = exp_q.pop_front();
          check("mon_pc", pc_out, t.pc);
          check("mon_pc_plus4", pc_plus4, t.pc + 32'd4);
          check("mon_instr", instr, t.ins);
          check("mon_count", retired_count, t.cnt);
          check("mon_mis_idle", 32'(misaligned), 32'd0);
        end
      end else if (!instr_valid && prev_v) begin
        if (mis_q.size() == 0) begin
          check("unexpected_commit", 32'(mis_q.size()), 32'd1);
        end else begin
          m = mis_q.pop_front();
          check("mon_misaligned", 32'(misaligned), 32'(m));
        end
      end else begin
        check("mon_mis_idle", 32'(misaligned), 32'd0);
      end
    end
    prev_v = instr_valid;
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    rs_value = '0;
    model_pc = RV; model_cnt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_pc", pc_out, RV);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);

    // Zero-wait nops: one instruction every two cycles.
    for (int i = 0; i < 3; i++) issue(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("nop_count3", retired_count, 32'd3);
    check("nop_pc3", pc_out, 32'h0040_000C);

    do_reset();
    issue(0, 32'h1000_0003, 0, 1, 0, 1, 0, 0, 32'h0);            // beq taken -> 0x10
    issue(0, 32'h1400_FFFF, 0, 0, 1, 0, 0, 0, 32'h0);            // bne taken, -4 -> 0x10
    issue(1, 32'h0000_0000, 0, 0, 0, 0, 1, 1, 32'h0040_0031);    // jr beats j, misaligned -> 0x30
    issue(0, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0);            // -> 0x34
    issue(3, 32'h0810_0008, 4, 0, 0, 0, 1, 0, 32'h0);            // j with waits and stall -> 0x20
    check("pre_rst_pc", pc_out, 32'h0040_0020);
    check("pre_rst_count", retired_count, 32'd5);

    // Reset while VALID, with a simultaneous ack and a would-be misaligned jr commit.
    begin
      txn_t t;
      t.pc = model_pc; t.ins = 32'h2222_3333; t.cnt = model_cnt;
      exp_q.push_back(t);
      imem_ack = 1'b1; imem_rdata = 32'h2222_3333;
      @(negedge clk);
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      stall = 1'b0; jump_reg = 1'b1; rs_value = 32'h0000_0003;
      @(negedge clk);
      reset = 1'b0; imem_ack = 1'b0;
      model_pc = RV; model_cnt = 32'd0;
      check("mid_rst_pc", pc_out, RV);
      check("mid_rst_count", retired_count, 32'd0);
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_req", 32'(imem_req), 32'd1);
      check("mid_rst_instr", instr, 32'd0);
    end
    issue(1, 32'h1000_0003, 0, 0, 1, 1, 0, 0, 32'h0);            // bne not taken -> 0x04
    issue(0, 32'h0000_0000, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);    // jr to top of memory
    issue(0, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 32'h0);            // wraps to 0
    check("wrap_pc", pc_out, 32'h0);

    for (int n = 0; n < 60; n++) begin
      issue(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mis_q_drained", 32'(mis_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
